// File: rtl/mult_16_seq_pkg.sv
// Shared constants and state encoding for the sequential shift-add multiplier.
package mult_16_seq_pkg;

    localparam int unsigned WORD_W   = 16;
    localparam int unsigned MUL_ITER = 16;
    localparam int unsigned CNT_W    = $clog2(MUL_ITER);

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_RUN  = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

endpackage

// File: rtl/add_16.sv
// 16-bit ripple-carry adder built from chained full-adder cells.
module add_16
    import mult_16_seq_pkg::*;
(
    input  logic [WORD_W-1:0] i_a,
    input  logic [WORD_W-1:0] i_b,
    input  logic              i_c_in,
    output logic [WORD_W-1:0] o_s,
    output logic              o_c_out
);

    logic [WORD_W:0] w_carry;

    assign w_carry[0] = i_c_in;

    for (genvar g = 0; g < WORD_W; g++) begin : g_bit
        fa u_fa (
            .i_a (i_a[g]),
            .i_b (i_b[g]),
            .i_c (w_carry[g]),
            .o_s (o_s[g]),
            .o_c (w_carry[g+1])
        );
    end

    assign o_c_out = w_carry[WORD_W];

endmodule

// File: rtl/fa.sv
// Single-bit full adder cell; the building block of the ripple-carry adder.
module fa (
    input  logic i_a,
    input  logic i_b,
    input  logic i_c,
    output logic o_s,
    output logic o_c
);

    logic w_p;

    assign w_p = i_a ^ i_b;
    assign o_s = w_p ^ i_c;
    assign o_c = (i_a & i_b) | (i_c & w_p);

endmodule

// File: rtl/mult_16_seq.sv
// Unsigned 16x16 shift-add multiplier: one add_16 pass per clock, 16 iterations
// per product, result held in {HI, LO} until the next accepted start.
module mult_16_seq
    import mult_16_seq_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_start,
    input  logic [WORD_W-1:0]   i_a,
    input  logic [WORD_W-1:0]   i_b,
    output logic                o_busy,
    output logic                o_done,
    output logic [2*WORD_W-1:0] o_p
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_ITER - 1);

    mul_state_e        r_state;
    mul_state_e        w_state_next;
    logic [WORD_W-1:0] r_m;
    logic [WORD_W-1:0] r_hi;
    logic [WORD_W-1:0] r_lo;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_accept;
    logic              w_iter;
    logic [WORD_W-1:0] w_addend;
    logic [WORD_W-1:0] w_sum;
    logic              w_carry;

    // start is only honoured outside RUN
    assign w_accept = i_start && (r_state == MUL_IDLE || r_state == MUL_DONE);
    assign w_iter   = (r_state == MUL_RUN);
    assign w_addend = r_lo[0] ? r_m : '0;

    add_16 u_add (
        .i_a     (r_hi),
        .i_b     (w_addend),
        .i_c_in  (1'b0),
        .o_s     (w_sum),
        .o_c_out (w_carry)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MUL_IDLE: if (i_start) w_state_next = MUL_RUN;
            MUL_RUN:  if (r_cnt == CNT_LAST) w_state_next = MUL_DONE;
            MUL_DONE: w_state_next = i_start ? MUL_RUN : MUL_IDLE;
            default:  w_state_next = MUL_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (r_state == MUL_RUN);
        o_done = (r_state == MUL_DONE);
        o_p    = {r_hi, r_lo};
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_m   <= '0;
            r_hi  <= '0;
            r_lo  <= '0;
            r_cnt <= '0;
        end else if (w_accept) begin
            r_m   <= i_a;
            r_hi  <= '0;
            r_lo  <= i_b;
            r_cnt <= '0;
        end else if (w_iter) begin
            // 33-bit {carry, sum, lo} shifted right by one; carry lands in HI msb
            r_hi  <= {w_carry, w_sum[WORD_W-1:1]};
            r_lo  <= {w_sum[0], r_lo[WORD_W-1:1]};
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_mult_16_seq.sv
// Self-checking bench for mult_16_seq: scoreboard of expected products pushed
// on each accepted start and compared when done is observed.
module tb_mult_16_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] p;

    int n_checks;
    int n_fail;
    logic [31:0] sb[$];

    mult_16_seq u_dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_a     (a),
        .i_b     (b),
        .o_busy  (busy),
        .o_done  (done),
        .o_p     (p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one start pulse (caller guarantees IDLE or DONE) and log the expected product.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib);
        logic [31:0] exp;
        start = 1'b1;
        a     = ia;
        b     = ib;
        exp   = {16'h0, ia} * {16'h0, ib};
        sb.push_back(exp);
        @(posedge clk); #1;
        start = 1'b0;
        a     = $urandom();
        b     = $urandom();
    endtask

    task automatic wait_done(input int max_cyc, output int cyc, output bit seen);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < max_cyc) begin
            @(posedge clk); #1;
            cyc++;
            if (done === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        start = 1'b0;
        a     = '0;
        b     = '0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b want=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b want=0", done); end
        n_checks++;
        if (p !== 32'h0) begin n_fail++; $display("FAIL reset_p got=%h want=0", p); end
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int          cyc;
        int          busy_cyc;
        logic [31:0] exp;
        issue(16'd3, 16'd5);
        cyc      = 0;
        busy_cyc = 0;
        while (done !== 1'b1 && cyc < 40) begin
            if (busy === 1'b1) busy_cyc++;
            @(posedge clk); #1;
            cyc++;
        end
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
        n_checks++;
        if (cyc !== 16) begin n_fail++; $display("FAIL basic_latency got=%0d want=16", cyc); end
        n_checks++;
        if (busy_cyc !== 16) begin n_fail++; $display("FAIL basic_busy_len got=%0d want=16", busy_cyc); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_with_done got=%b want=0", busy); end
        n_checks++;
        if (p !== exp) begin n_fail++; $display("FAIL basic_p got=%h want=%h", p, exp); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL basic_done_pulse got=%b want=0", done); end
        n_checks++;
        if (p !== 32'h0000000F) begin n_fail++; $display("FAIL basic_p_hold got=%h want=0000000f", p); end
    endtask

    task automatic test_patterns();
        logic [15:0] va[5];
        logic [15:0] vb[5];
        logic [31:0] exp;
        int          cyc;
        bit          seen;
        va = '{16'hFFFF, 16'h0000, 16'h8000, 16'hABCD, 16'h0001};
        vb = '{16'hFFFF, 16'h1234, 16'h0002, 16'h1357, 16'hFFFF};
        for (int i = 0; i < 5; i++) begin
            issue(va[i], vb[i]);
            wait_done(40, cyc, seen);
            exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
            n_checks++;
            if (!seen || cyc !== 16) begin
                n_fail++;
                $display("FAIL pattern%0d_latency got=%0d seen=%b want=16", i, cyc, seen);
            end
            n_checks++;
            if (p !== exp) begin n_fail++; $display("FAIL pattern%0d_p got=%h want=%h", i, p, exp); end
        end
        // Exact anchors independent of the multiply model
        n_checks++;
        if (va[0] * vb[0] !== 16'h0001 || {16'h0, va[2]} * {16'h0, vb[2]} !== 32'h00010000) begin
            n_fail++;
            $display("FAIL pattern_anchor got=model want=fffe0001/00010000");
        end
    endtask

    task automatic test_start_ignored();
        logic [31:0] exp;
        int          cyc;
        bit          seen;
        issue(16'd7, 16'd9);
        repeat (4) @(posedge clk);
        #1;
        start = 1'b1;
        a     = 16'd100;
        b     = 16'd100;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(40, cyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
        n_checks++;
        if (!seen || cyc !== 11) begin
            n_fail++;
            $display("FAIL ignored_latency got=%0d seen=%b want=11", cyc, seen);
        end
        n_checks++;
        if (p !== exp || p !== 32'd63) begin n_fail++; $display("FAIL ignored_p got=%h want=%h", p, exp); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_run();
        logic [31:0] exp;
        int          cyc;
        bit          seen;
        issue(16'h1234, 16'h5678);
        repeat (7) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy got=%b want=0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL midrst_done got=%b want=0", done); end
        n_checks++;
        if (p !== 32'h0) begin n_fail++; $display("FAIL midrst_p got=%h want=0", p); end
        #2;
        rst_n = 1'b1;
        @(posedge clk); #1;
        wait_done(40, cyc, seen);
        n_checks++;
        if (seen || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_idle got=done:%b busy:%b want=0/0", seen, busy);
        end
        issue(16'h1234, 16'h5678);
        wait_done(40, cyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
        n_checks++;
        if (!seen || cyc !== 16) begin
            n_fail++;
            $display("FAIL midrst_rerun_latency got=%0d seen=%b want=16", cyc, seen);
        end
        n_checks++;
        if (p !== exp || p !== 32'h06260060) begin
            n_fail++;
            $display("FAIL midrst_rerun_p got=%h want=06260060", p);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int          cyc;
        bit          seen;
        start = 1'b1;
        a     = 16'd2;
        b     = 16'd3;
        sb.push_back(32'd6);
        @(posedge clk); #1;
        wait_done(40, cyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
        n_checks++;
        if (!seen || p !== exp) begin n_fail++; $display("FAIL b2b_first_p got=%h want=%h", p, exp); end
        a = 16'd4;
        b = 16'd5;
        sb.push_back(32'd20);
        @(posedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_accept got=busy:%b done:%b want=1/0", busy, done);
        end
        wait_done(40, cyc, seen);
        exp = (sb.size() > 0) ? sb.pop_front() : 32'hx;
        n_checks++;
        if (!seen || cyc !== 16) begin
            n_fail++;
            $display("FAIL b2b_second_latency got=%0d seen=%b want=16", cyc, seen);
        end
        n_checks++;
        if (p !== exp) begin n_fail++; $display("FAIL b2b_second_p got=%h want=%h", p, exp); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_idle got=busy:%b done:%b want=0/0", busy, done);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b1;
        start    = 1'b0;
        a        = '0;
        b        = '0;
        #2;
        test_reset();
        test_basic();
        test_patterns();
        test_start_ignored();
        test_reset_mid_run();
        test_back_to_back();
        n_checks++;
        if (sb.size() !== 0) begin n_fail++; $display("FAIL scoreboard_empty got=%0d want=0", sb.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
